uc_multiciclo_fsm: RTL
======================

// Module: uc_multiciclo_fsm
// PURPOSE
//  Multicycle control unit that sequences the RV64 datapath (PC, IR, register file, ALU, data RAM).
//  Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and handshakes with the
//  instruction and data memories, inserting wait states until ack.
//  Drives the datapath control bus and keeps a retired-instruction counter.
// PARAMETERS
//  TIMEOUT  16  max wait cycles for an ack in FETCH/MEM before ERROR; 0 disables the timeout
//  CNT_W    32  width of instret_cnt
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      reset, asynchronous, active-high
//  start        in   1      leave IDLE and begin fetching
//  opcode       in   7      IR[6:0] from datapath
//  i_mem_ack    in   1      instruction word valid on i_mem_data
//  d_mem_ack    in   1      data RAM access complete / read data valid
//  i_mem_req    out  1      instruction fetch request
//  d_mem_req    out  1      data RAM request
//  d_mem_we     out  1      data RAM write (store)
//  ir_we        out  1      load IR
//  pc_we        out  1      update PC (PC+4, or PC+imm when pc_src=1 and branch taken)
//  rf_we        out  1      register file write
//  rf_src       out  1      0: ALU result, 1: RAM data to RF
//  alu_src      out  1      0: doutB, 1: immediate
//  pc_src       out  1      branch select
//  alu_cmd      out  4      0000 ADD, 0001 SUB, 0010 R-type funct, 0011 I-type funct
//  busy         out  1      state not IDLE/HALT/ERROR
//  halted       out  1      in HALT
//  err          out  1      in ERROR (sticky until reset)
//  state        out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 ERROR=7
//  instret_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE, instret_cnt=0, wait counter=0, opcode class=NONE; all outputs 0.
//  Registers: state, 3-bit opcode class (latched in DECODE), wait counter, instret_cnt.
//  Control outputs are decoded from state, class, and the current-cycle ack; all are 0 unless listed.
//  Opcode classes: 0110011 R, 0010011 I, 0000011 LD, 0100011 ST, 1100011 BR, 1110011 SYS; other = ILL.
//  IDLE: start=1 -> FETCH; otherwise stay in IDLE.
//  FETCH: i_mem_req=1. When i_mem_ack=1: ir_we=1 in the same cycle -> DECODE.
//  DECODE: one cycle, latches class. SYS -> HALT; ILL -> ERROR; otherwise -> EXEC.
//  EXEC:
//   - R: alu_src=0, alu_cmd=0010 -> WB.
//   - I: alu_src=1, alu_cmd=0011 -> WB.
//   - LD/ST: alu_src=1, alu_cmd=0000 -> MEM.
//   - BR: alu_src=0, alu_cmd=0001, pc_src=1, pc_we=1 -> FETCH.
//  MEM: d_mem_req=1, alu_src=1, alu_cmd=0000 held every cycle. d_mem_we=1 for ST.
//   When d_mem_ack=1:
//   - ST: pc_we=1 -> FETCH.
//   - LD: rf_we=1, rf_src=1, pc_we=1 -> FETCH.
//  WB: rf_we=1, rf_src=0, alu_src/alu_cmd as in EXEC for the class, pc_we=1 -> FETCH.
//  Per-class latency, zero wait states:
//   - R/I: 4 cycles (FETCH-DECODE-EXEC-WB).
//   - BR: 3 cycles.
//   - LD/ST: 4 cycles.
//  pc_we pulses exactly once per retired instruction, in its last cycle.
//   instret_cnt increments on that edge; all-ones wraps to 0.
//  Wait counter: cleared on entry to FETCH/MEM; increments each cycle without ack.
//   When TIMEOUT!=0 and the count reaches TIMEOUT with no ack -> ERROR.
//   An ack in that same cycle wins.
//  Acks outside the matching request state are ignored.
//  An ack held high across states counts only in FETCH/MEM.
//  start is ignored outside IDLE.
//  HALT and ERROR are terminal: no requests or enables; exit only by reset.
//  Reset mid-operation: asynchronous.
//   All requests/enables drop immediately and the state returns to IDLE.
//   An in-flight store is abandoned; the RAM must tolerate req falling without ack.
// TESTING
//  1. Reset, start, R-type (0110011), immediate acks:
//     - FETCH, DECODE, EXEC(alu_cmd=0010), WB(rf_we=1, pc_we=1).
//     - instret_cnt=1 after 4 cycles.
//  2. Load with d_mem_ack delayed 3 cycles:
//     - d_mem_req held 4 cycles, d_mem_we=0.
//     - On the ack cycle: rf_we=1, rf_src=1, pc_we=1.
//     - Total 7 cycles.
//  3. Store then branch:
//     - Store: d_mem_we=1 only in MEM.
//     - Branch: EXEC has pc_src=1, pc_we=1, alu_cmd=0001; 3 cycles; instret_cnt=2.
//  4. TIMEOUT=4, i_mem_ack held 0:
//     - After 4 FETCH wait cycles: state=7, err=1, i_mem_req=0.
//     - start ignored; rst_n pulse returns to IDLE.
//  5. Opcode 1110011 -> HALT (halted=1, busy=0).
//     Opcode 1111111 -> ERROR with no rf_we/pc_we.
//  6. rst_n asserted mid-MEM of a store:
//     - d_mem_req/d_mem_we fall in the same cycle (asynchronously).
//     - instret_cnt=0; state=IDLE.

Source files
------------

// File: rtl/uc_multiciclo_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB for the RV64 datapath, counts retirements.
// Latency: R/I/LD/ST 4 cycles, BR 3 cycles with zero wait states; each unacked FETCH/MEM cycle adds one.
// Backpressure: FETCH/MEM hold their request until ack; TIMEOUT unacked cycles there lands in ERROR.
module uc_multiciclo_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             i_mem_ack,
    input  logic             d_mem_ack,
    output logic             i_mem_req,
    output logic             d_mem_req,
    output logic             d_mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             rf_src,
    output logic             alu_src,
    output logic             pc_src,
    output logic [3:0]       alu_cmd,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_I    = 3'd2,
        C_LD   = 3'd3,
        C_ST   = 3'd4,
        C_BR   = 3'd5,
        C_SYS  = 3'd6,
        C_ILL  = 3'd7
    } cls_t;

    // Wait counter only needs to reach TIMEOUT-1: the TIMEOUT-th unacked cycle is the one that trips ERROR.
    localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;
    localparam bit                TO_EN     = (TIMEOUT != 0);

    state_t             state_q, state_d;
    cls_t               cls_q, cls_d, dec_cls;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    function automatic cls_t decode_cls(input logic [6:0] op);
        case (op)
            7'b0110011: decode_cls = C_R;
            7'b0010011: decode_cls = C_I;
            7'b0000011: decode_cls = C_LD;
            7'b0100011: decode_cls = C_ST;
            7'b1100011: decode_cls = C_BR;
            7'b1110011: decode_cls = C_SYS;
            default:    decode_cls = C_ILL;
        endcase
    endfunction

    // Next-state and control-bus decode from state, latched class and this cycle's ack.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = wait_q;
        i_mem_req = 1'b0;
        d_mem_req = 1'b0;
        d_mem_we  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        rf_src    = 1'b0;
        alu_src   = 1'b0;
        pc_src    = 1'b0;
        alu_cmd   = 4'b0000;
        dec_cls   = decode_cls(opcode);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                i_mem_req = 1'b1;
                if (i_mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (TO_EN && wait_q == WAIT_LAST) state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    C_SYS:   state_d = S_HALT;
                    C_ILL:   state_d = S_ERROR;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_cmd = 4'b0010;
                        state_d = S_WB;
                    end
                    C_I: begin
                        alu_src = 1'b1;
                        alu_cmd = 4'b0011;
                        state_d = S_WB;
                    end
                    C_LD, C_ST: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    C_BR: begin
                        alu_cmd = 4'b0001;
                        pc_src  = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end
                    default: state_d = S_ERROR;
                endcase
            end
            S_MEM: begin
                // Address stays on the ALU for the whole access, so the RAM sees a stable request.
                d_mem_req = 1'b1;
                alu_src   = 1'b1;
                d_mem_we  = (cls_q == C_ST);
                if (d_mem_ack) begin
                    pc_we   = 1'b1;
                    rf_we   = (cls_q == C_LD);
                    rf_src  = (cls_q == C_LD);
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (TO_EN && wait_q == WAIT_LAST) state_d = S_ERROR;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                alu_src = (cls_q == C_I);
                alu_cmd = (cls_q == C_I) ? 4'b0011 : 4'b0010;
                state_d = S_FETCH;
                wait_d  = '0;
            end
            default: ;  // HALT and ERROR hold until reset
        endcase

        instret_d = pc_we ? instret_q + 1'b1 : instret_q;
    end

    // State, class, wait counter and retirement counter; reset lands everything in IDLE at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_NONE;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
    assign halted      = (state_q == S_HALT);
    assign err         = (state_q == S_ERROR);
    assign state       = state_q;
    assign instret_cnt = instret_q;

endmodule
